multi_queue_shared_buffer: RTL and testbench
============================================

Name: multi_queue_shared_buffer

Overview:
Successor of the per-core queueing domain. N logical FIFO queues share one packet buffer of BUFFER_DEPTH slots. Slot addresses come from an internal free-list, and each queue holds its own slot-pointer FIFO. New over the previous generation:
- free-list built by a reset-time init FSM (no init file)
- per-queue occupancy counters and quotas
- push ready/backpressure
- registered head read with valid
- defined arbitration for non-one-hot requests

The block sits between dispatcher and scheduler.

Parameters:
NUMBER_OF_QUEUES, 4, number of logical queues (>=1)
DATA_SIZE, 678, packet width in bits
BUFFER_DEPTH, 16, shared slots; power of two, >=2
REGISTER_SIZE, 32, width of threshold/quota configuration words
Derived: AW=$clog2(BUFFER_DEPTH), CW=$clog2(BUFFER_DEPTH+1), QW=max(1,$clog2(NUMBER_OF_QUEUES))

Ports:
clock  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high
push_packet  in  DATA_SIZE  packet to enqueue
push_valid  in  NUMBER_OF_QUEUES  enqueue request, intended one-hot
push_ready  out  NUMBER_OF_QUEUES  queue i can accept this cycle
pop_valid  in  NUMBER_OF_QUEUES  head consumed, intended one-hot
read_queue_id  in  QW  queue whose head is presented
head_packet  out  DATA_SIZE  head of selected queue, registered
head_valid  out  1  head_packet is meaningful
queues_higher_threshold  in  NUMBER_OF_QUEUES x REGISTER_SIZE  kill threshold; 0 disables
queues_quota  in  NUMBER_OF_QUEUES x REGISTER_SIZE  max occupancy; 0 = unlimited
occupancy  out  NUMBER_OF_QUEUES x CW  entries held per queue
empty  out  NUMBER_OF_QUEUES  occupancy==0
full  out  NUMBER_OF_QUEUES  ~push_ready
free_count  out  CW  unallocated slots
kill_the_core  out  NUMBER_OF_QUEUES  occupancy >= threshold (threshold!=0)
init_done  out  1  free-list initialised

Behaviour:
- Reset:
  - FSM enters INIT.
  - occupancy=0, empty=all 1, free_count=0, push_ready=0, full=all 1, head_valid=0, head_packet=0, kill_the_core=0, init_done=0.
- INIT:
  - Counter k runs 0..BUFFER_DEPTH-1, one cycle each, writing slot k into the free-list.
  - After BUFFER_DEPTH cycles, go to RUN: free_count=BUFFER_DEPTH, init_done=1.
  - push_valid and pop_valid are ignored in INIT.
- RUN:
  - push_ready[i] = init_done & (free_count!=0) & (quota[i]==0 | occupancy[i]<quota[i]). Computed from registered state only; a same-cycle pop does not enable a push.
- Push arbitration: the accepted push is the lowest index i with push_valid[i]&push_ready[i]. Other bits are dropped silently.
- Accepted push:
  - Slot = free-list head.
  - buffer[slot] <= push_packet; slot is appended to queue i's pointer FIFO.
  - free_count-1; occupancy[i]+1.
- Pop arbitration: the accepted pop is the lowest index j with pop_valid[j]&~empty[j]. Pops on empty queues are ignored.
- Accepted pop: head slot of queue j is removed and appended to the free-list tail; free_count+1; occupancy[j]-1.
- Simultaneous push and pop:
  - Both take effect; free_count is unchanged.
  - A freed slot is reusable from the next cycle.
  - If i==j, occupancy[i] is unchanged.
  - Pop of the last entry plus push to the same queue is legal; the queue then holds only the new entry.
- Head read:
  - Latency 1 cycle.
  - head_packet <= buffer[head_ptr[read_queue_id]].
  - head_valid <= ~empty[read_queue_id], using pre-update state.
  - An out-of-range read_queue_id gives head_valid=0.
- kill_the_core[i]: registered, equals (threshold[i]!=0)&(occupancy[i]>=threshold[i]) evaluated on the updated occupancy.
- Pointers:
  - All FIFO pointers wrap modulo BUFFER_DEPTH.
  - The free-list never overflows, because the number of slots is conserved.
  - Invariant: sum(occupancy)+free_count==BUFFER_DEPTH in RUN.
- Threshold/quota comparisons zero-extend occupancy to REGISTER_SIZE.
- Reset mid-operation: all contents are discarded and INIT restarts; the buffer RAM is not cleared.

Test Plan:
1. Reset, idle -> init_done rises exactly 16 cycles after reset release; free_count=16; all empty=1, push_ready=4'b1111.
2. Push A,B,C to q1, read_queue_id=1, pop q1 three times -> head_packet A,B,C in order, one cycle after each select/pop; then head_valid=0, occupancy[1]=0, free_count=16.
3. quota[2]=3: push q2 four times -> fourth push not accepted; push_ready[2]=0, occupancy[2]=3, free_count=13; after one pop, push_ready[2]=1.
4. Fill pool: 16 pushes across q0/q3 -> free_count=0, full=4'b1111. Then same-cycle pop q0 + push q3 -> push rejected, pop accepted; next cycle free_count=1, push accepted.
5. push_valid=4'b0110, pop_valid=4'b1010 with q1, q3 non-empty -> only q1 pushed and q1 popped; occupancy[1] unchanged, others unchanged.
6. threshold[0]=2: push q0 twice -> kill_the_core[0]=1 the cycle after the 2nd push; pop once -> 0. Assert reset mid-run -> all outputs return to reset values and INIT repeats.

Source files
------------

// File: rtl/multi_queue_shared_buffer.sv
// Multi-queue shared packet buffer: N logical FIFOs carve slots out of one
// shared RAM. Free slots circulate through a free-list that is seeded by an
// init sequence after reset; each queue keeps its own FIFO of slot pointers.
module multi_queue_shared_buffer #(
  parameter int unsigned NUMBER_OF_QUEUES = 4,
  parameter int unsigned DATA_SIZE        = 678,
  parameter int unsigned BUFFER_DEPTH     = 16,
  parameter int unsigned REGISTER_SIZE    = 32,
  localparam int unsigned AW = $clog2(BUFFER_DEPTH),
  localparam int unsigned CW = $clog2(BUFFER_DEPTH + 1),
  localparam int unsigned QW = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [DATA_SIZE-1:0]                             push_packet,
  input  logic [NUMBER_OF_QUEUES-1:0]                      push_valid,
  output logic [NUMBER_OF_QUEUES-1:0]                      push_ready,
  input  logic [NUMBER_OF_QUEUES-1:0]                      pop_valid,
  input  logic [QW-1:0]                                    read_queue_id,
  output logic [DATA_SIZE-1:0]                             head_packet,
  output logic                                             head_valid,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   queues_higher_threshold,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]   queues_quota,
  output logic [NUMBER_OF_QUEUES-1:0][CW-1:0]              occupancy,
  output logic [NUMBER_OF_QUEUES-1:0]                      empty,
  output logic [NUMBER_OF_QUEUES-1:0]                      full,
  output logic [CW-1:0]                                    free_count,
  output logic [NUMBER_OF_QUEUES-1:0]                      kill_the_core,
  output logic                                             init_done
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e               state_q;
  logic [AW-1:0]        init_cnt_q;
  logic                 init_done_q;
  logic [AW-1:0]        free_head_q, free_tail_q;
  logic [CW-1:0]        free_count_q, free_count_d;
  logic [AW-1:0]        q_head_q [NUMBER_OF_QUEUES];
  logic [AW-1:0]        q_tail_q [NUMBER_OF_QUEUES];
  logic [CW-1:0]        occ_q    [NUMBER_OF_QUEUES];
  logic [CW-1:0]        occ_d    [NUMBER_OF_QUEUES];
  logic [NUMBER_OF_QUEUES-1:0] kill_q;
  logic [DATA_SIZE-1:0] head_packet_q;
  logic                 head_valid_q;

  // Storage arrays (not reset; the free-list is rebuilt by the init sequence).
  logic [AW-1:0]        free_mem   [BUFFER_DEPTH];
  logic [AW-1:0]        qp_mem     [NUMBER_OF_QUEUES][BUFFER_DEPTH];
  logic [DATA_SIZE-1:0] buffer_mem [BUFFER_DEPTH];

  logic                 push_hit, pop_hit;
  logic [QW-1:0]        push_idx, pop_idx;
  logic [AW-1:0]        push_slot, pop_slot;
  logic                 rq_ok;
  logic [QW-1:0]        rq_idx;
  logic                 rd_valid;

  // Status outputs and push readiness, derived from registered state only.
  always_comb begin
    push_ready = '0;
    empty      = '0;
    occupancy  = '0;
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      empty[i]      = (occ_q[i] == '0);
      occupancy[i]  = occ_q[i];
      push_ready[i] = init_done_q && (free_count_q != '0) &&
                      ((queues_quota[i] == '0) ||
                       (REGISTER_SIZE'(occ_q[i]) < queues_quota[i]));
    end
    full = ~push_ready;
  end

  // Lowest-index arbitration; descending scan lets the lowest index win.
  always_comb begin
    push_hit = 1'b0;
    push_idx = '0;
    pop_hit  = 1'b0;
    pop_idx  = '0;
    for (int i = NUMBER_OF_QUEUES - 1; i >= 0; i--) begin
      if (push_valid[i] && push_ready[i]) begin
        push_hit = 1'b1;
        push_idx = QW'(i);
      end
      if (init_done_q && pop_valid[i] && !empty[i]) begin
        pop_hit = 1'b1;
        pop_idx = QW'(i);
      end
    end
    push_slot = free_mem[free_head_q];
    pop_slot  = qp_mem[pop_idx][q_head_q[pop_idx]];
    rq_ok     = (32'(read_queue_id) < NUMBER_OF_QUEUES);
    rq_idx    = rq_ok ? read_queue_id : '0;
    rd_valid  = rq_ok && !empty[rq_idx];
  end

  // Next occupancy and free count; a same-queue push+pop nets to zero.
  always_comb begin
    for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
      occ_d[i] = occ_q[i];
      if (push_hit && (push_idx == QW'(i))) occ_d[i] = occ_d[i] + CW'(1);
      if (pop_hit && (pop_idx == QW'(i)))   occ_d[i] = occ_d[i] - CW'(1);
    end
    free_count_d = free_count_q;
    if (push_hit && !pop_hit) free_count_d = free_count_q - CW'(1);
    if (pop_hit && !push_hit) free_count_d = free_count_q + CW'(1);
  end

  // Control FSM, pointers, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      free_head_q   <= '0;
      free_tail_q   <= '0;
      free_count_q  <= '0;
      kill_q        <= '0;
      head_packet_q <= '0;
      head_valid_q  <= 1'b0;
      for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
        q_head_q[i] <= '0;
        q_tail_q[i] <= '0;
        occ_q[i]    <= '0;
      end
    end else begin
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + AW'(1);
          // Free-list is full after the last write, so its tail wraps back to 0.
          if (init_cnt_q == AW'(BUFFER_DEPTH - 1)) begin
            state_q      <= StRun;
            init_done_q  <= 1'b1;
            free_count_q <= CW'(BUFFER_DEPTH);
          end
        end
        StRun: begin
          free_count_q <= free_count_d;
          if (push_hit) begin
            free_head_q        <= free_head_q + AW'(1);
            q_tail_q[push_idx] <= q_tail_q[push_idx] + AW'(1);
          end
          if (pop_hit) begin
            free_tail_q       <= free_tail_q + AW'(1);
            q_head_q[pop_idx] <= q_head_q[pop_idx] + AW'(1);
          end
          for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            occ_q[i]  <= occ_d[i];
            kill_q[i] <= (queues_higher_threshold[i] != '0) &&
                         (REGISTER_SIZE'(occ_d[i]) >= queues_higher_threshold[i]);
          end
          head_valid_q <= rd_valid;
          if (rd_valid) head_packet_q <= buffer_mem[qp_mem[rq_idx][q_head_q[rq_idx]]];
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Array writes: free-list seeding during init, then slot traffic in run.
  always_ff @(posedge clock) begin
    if (state_q == StInit) begin
      free_mem[init_cnt_q] <= init_cnt_q;
    end else begin
      if (pop_hit) free_mem[free_tail_q] <= pop_slot;
      if (push_hit) begin
        buffer_mem[push_slot]                <= push_packet;
        qp_mem[push_idx][q_tail_q[push_idx]] <= push_slot;
      end
    end
  end

  assign free_count    = free_count_q;
  assign kill_the_core = kill_q;
  assign head_packet   = head_packet_q;
  assign head_valid    = head_valid_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_multi_queue_shared_buffer.sv
// Directed bench for multi_queue_shared_buffer: init sequence, FIFO order,
// quotas, pool exhaustion, arbitration, kill thresholds and mid-run reset.
module tb_multi_queue_shared_buffer;

  localparam int NQ = 4;
  localparam int DS = 678;
  localparam int BD = 16;
  localparam int RS = 32;
  localparam int CW = 5;
  localparam int QW = 2;

  logic                    clock;
  logic                    reset;
  logic [DS-1:0]           push_packet;
  logic [NQ-1:0]           push_valid;
  logic [NQ-1:0]           push_ready;
  logic [NQ-1:0]           pop_valid;
  logic [QW-1:0]           read_queue_id;
  logic [DS-1:0]           head_packet;
  logic                    head_valid;
  logic [NQ-1:0][RS-1:0]   thr;
  logic [NQ-1:0][RS-1:0]   quota;
  logic [NQ-1:0][CW-1:0]   occupancy;
  logic [NQ-1:0]           empty;
  logic [NQ-1:0]           full;
  logic [CW-1:0]           free_count;
  logic [NQ-1:0]           kill_the_core;
  logic                    init_done;

  int n_cmp = 0;
  int n_err = 0;

  multi_queue_shared_buffer #(
    .NUMBER_OF_QUEUES (NQ),
    .DATA_SIZE        (DS),
    .BUFFER_DEPTH     (BD),
    .REGISTER_SIZE    (RS)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .push_packet             (push_packet),
    .push_valid              (push_valid),
    .push_ready              (push_ready),
    .pop_valid               (pop_valid),
    .read_queue_id           (read_queue_id),
    .head_packet             (head_packet),
    .head_valid              (head_valid),
    .queues_higher_threshold (thr),
    .queues_quota            (quota),
    .occupancy               (occupancy),
    .empty                   (empty),
    .full                    (full),
    .free_count              (free_count),
    .kill_the_core           (kill_the_core),
    .init_done               (init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick(input int n = 1);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [DS-1:0] mk(input logic [31:0] v);
    mk = {v, 614'h0, v};
  endfunction

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_occ"},   occupancy, '0);
    check_eq({tag, "_empty"}, empty, 4'hF);
    check_eq({tag, "_free"},  free_count, 0);
    check_eq({tag, "_ready"}, push_ready, 4'h0);
    check_eq({tag, "_full"},  full, 4'hF);
    check_eq({tag, "_hv"},    head_valid, 0);
    check_eq({tag, "_hp"},    head_packet, 0);
    check_eq({tag, "_kill"},  kill_the_core, 4'h0);
    check_eq({tag, "_idone"}, init_done, 0);
  endtask

  task automatic run_init(input string tag);
    reset = 1'b0;
    tick(15);
    check_eq({tag, "_idone15"}, init_done, 0);
    tick(1);
    check_eq({tag, "_idone16"}, init_done, 1);
    check_eq({tag, "_free16"},  free_count, 16);
    check_eq({tag, "_empty"},   empty, 4'hF);
    check_eq({tag, "_ready"},   push_ready, 4'hF);
  endtask

  initial begin
    reset = 1'b1;
    push_packet = '0;
    push_valid = '0;
    pop_valid = '0;
    read_queue_id = '0;
    thr = '0;
    quota = '0;
    #1;
    tick(2);

    // 1: reset values and init timing
    check_reset_state("rst");
    run_init("init");

    // 2: FIFO order on q1 through the registered head read
    read_queue_id = 2'd1;
    push_valid = 4'b0010;
    push_packet = mk(32'hA);
    tick();
    push_packet = mk(32'hB);
    tick();
    push_packet = mk(32'hC);
    tick();
    push_valid = '0;
    check_eq("q1_occ3", occupancy[1], 3);
    check_eq("q1_free13", free_count, 13);
    tick();
    check_eq("q1_head_A_idle", head_packet, mk(32'hA));
    pop_valid = 4'b0010;
    tick();
    check_eq("q1_head_A", head_packet, mk(32'hA));
    check_eq("q1_hv_A", head_valid, 1);
    tick();
    check_eq("q1_head_B", head_packet, mk(32'hB));
    tick();
    check_eq("q1_head_C", head_packet, mk(32'hC));
    pop_valid = '0;
    tick();
    check_eq("q1_hv_empty", head_valid, 0);
    check_eq("q1_occ0", occupancy[1], 0);
    check_eq("q1_free16", free_count, 16);

    // 3: quota on q2
    quota[2] = 32'd3;
    push_valid = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      push_packet = mk(32'h20 + k);
      tick();
    end
    push_valid = '0;
    check_eq("quota_occ3", occupancy[2], 3);
    check_eq("quota_free13", free_count, 13);
    check_eq("quota_ready0", push_ready[2], 0);
    check_eq("quota_full1", full[2], 1);
    pop_valid = 4'b0100;
    tick();
    pop_valid = '0;
    check_eq("quota_occ2", occupancy[2], 2);
    check_eq("quota_ready1", push_ready[2], 1);
    pop_valid = 4'b0100;
    tick(2);
    pop_valid = '0;
    quota[2] = '0;
    check_eq("quota_drained", occupancy[2], 0);
    check_eq("quota_free16", free_count, 16);

    // 4: exhaust the pool across q0/q3, then pop+push with no free slot
    read_queue_id = 2'd3;
    for (int k = 0; k < 16; k++) begin
      push_valid = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      push_packet = mk(32'h100 + k);
      tick();
    end
    push_valid = '0;
    check_eq("pool_free0", free_count, 0);
    check_eq("pool_full", full, 4'hF);
    check_eq("pool_occ0", occupancy[0], 8);
    check_eq("pool_occ3", occupancy[3], 8);
    check_eq("pool_head3", head_packet, mk(32'h101));
    push_valid = 4'b1000;
    pop_valid = 4'b0001;
    push_packet = mk(32'h1FF);
    tick();
    pop_valid = '0;
    check_eq("pool_rej_free1", free_count, 1);
    check_eq("pool_rej_occ0", occupancy[0], 7);
    check_eq("pool_rej_occ3", occupancy[3], 8);
    tick();
    push_valid = '0;
    check_eq("pool_acc_free0", free_count, 0);
    check_eq("pool_acc_occ3", occupancy[3], 9);
    pop_valid = 4'b0001;
    tick(7);
    pop_valid = '0;
    check_eq("pool_q0_drained", occupancy[0], 0);

    // 5: non-one-hot requests resolve to the lowest eligible index
    push_valid = 4'b0010;
    push_packet = mk(32'h200);
    tick();
    check_eq("arb_pre_free", free_count, 6);
    push_valid = 4'b0110;
    pop_valid = 4'b1010;
    push_packet = mk(32'h201);
    read_queue_id = 2'd1;
    tick();
    push_valid = '0;
    pop_valid = '0;
    check_eq("arb_occ", occupancy, {5'd9, 5'd0, 5'd1, 5'd0});
    check_eq("arb_free", free_count, 6);
    tick();
    check_eq("arb_head_q1", head_packet, mk(32'h201));
    check_eq("arb_hv_q1", head_valid, 1);

    // 6: kill threshold on q0, then reset mid-run
    thr[0] = 32'd2;
    push_valid = 4'b0001;
    push_packet = mk(32'h300);
    tick();
    check_eq("kill_after1", kill_the_core, 4'b0000);
    push_packet = mk(32'h301);
    tick();
    push_valid = '0;
    check_eq("kill_after2", kill_the_core, 4'b0001);
    pop_valid = 4'b0001;
    tick();
    pop_valid = '0;
    check_eq("kill_after_pop", kill_the_core, 4'b0000);
    reset = 1'b1;
    tick();
    check_reset_state("mid");
    run_init("reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
